// File: rtl/iq_burst_source.sv
// Framed I/Q burst generator: alternating preamble, LFSR-driven QPSK payload and zero gap
// at one of four amplitudes, presented through a registered valid/ready output stage.
module iq_burst_source #(
  parameter int unsigned PREAMBLE_LEN = 16,
  parameter int unsigned PAYLOAD_LEN  = 64,
  parameter int unsigned GAP_LEN      = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        amp,
  input  logic              ready,
  output logic signed [3:0] x_i_out,
  output logic signed [3:0] x_q_out,
  output logic              valid,
  output logic [1:0]        sym_bits,
  output logic              busy,
  output logic              frame_done
);

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] PAY_LAST = 16'(PAYLOAD_LEN - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_LEN - 1);

  typedef enum logic [1:0] {IDLE, PRE, PAY, GAP} state_t;

  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [15:0] lfsr, lfsr_d;
  logic [1:0]  amp_q, amp_d;
  logic        done_d;
  logic        accept;
  logic        is_last;
  logic        data_en;
  logic [1:0]  sym_d;
  logic signed [3:0] xi_d, xq_d;

  function automatic logic [15:0] last_idx(input state_t s);
    case (s)
      PRE:     return PRE_LAST;
      PAY:     return PAY_LAST;
      default: return GAP_LAST;
    endcase
  endfunction

  // bit 0 maps to +A, bit 1 to -A.
  function automatic logic signed [3:0] level(input logic [1:0] idx, input logic bit_v);
    logic signed [3:0] mag;
    case (idx)
      2'd0:    mag = 4'sd1;
      2'd1:    mag = 4'sd2;
      2'd2:    mag = 4'sd4;
      default: mag = 4'sd7;
    endcase
    return bit_v ? -mag : mag;
  endfunction

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    state_d = state;
    cnt_d   = cnt;
    lfsr_d  = lfsr;
    amp_d   = amp_q;
    done_d  = 1'b0;
    accept  = valid && ready;
    is_last = (cnt == last_idx(state));

    case (state)
      IDLE: begin
        if (start) begin
          state_d = PRE;
          cnt_d   = '0;
          amp_d   = amp;
        end
      end
      default: begin
        if (accept) begin
          if (state == PAY)
            lfsr_d = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
          if (is_last) begin
            cnt_d = '0;
            case (state)
              PRE:     state_d = PAY;
              PAY:     state_d = GAP;
              default: begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            endcase
          end else begin
            cnt_d = cnt + 16'd1;
          end
        end
      end
    endcase

    // Output stage is computed from the next state so it registers in step with it.
    case (state_d)
      PRE:     sym_d = {2{cnt_d[0]}};
      PAY:     sym_d = lfsr_d[1:0];
      default: sym_d = 2'b00;
    endcase
    data_en = (state_d == PRE) || (state_d == PAY);
    xi_d    = data_en ? level(amp_d, sym_d[1]) : 4'sd0;
    xq_d    = data_en ? level(amp_d, sym_d[0]) : 4'sd0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      lfsr       <= SEED;
      amp_q      <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      sym_bits   <= 2'b00;
      x_i_out    <= 4'sd0;
      x_q_out    <= 4'sd0;
    end else begin
      cnt        <= cnt_d;
      lfsr       <= lfsr_d;
      amp_q      <= amp_d;
      valid      <= (state_d != IDLE);
      busy       <= (state_d != IDLE);
      frame_done <= done_d;
      sym_bits   <= sym_d;
      x_i_out    <= xi_d;
      x_q_out    <= xq_d;
    end
  end

endmodule

// File: tb/tb_iq_burst_source.sv
// Self-checking bench for iq_burst_source: each burst is predicted sample-by-sample
// from a queue-based model and compared on the falling edge.
module tb_iq_burst_source;

  localparam int          PRE_LEN = 16;
  localparam int          PAY_LEN = 64;
  localparam int          GAP_LEN = 8;
  localparam int          TOTAL   = PRE_LEN + PAY_LEN + GAP_LEN;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic              clk   = 1'b0;
  logic              rst   = 1'b0;
  logic              start = 1'b0;
  logic              ready = 1'b0;
  logic [1:0]        amp   = 2'd0;
  logic signed [3:0] x_i_out, x_q_out;
  logic              valid, busy, frame_done;
  logic [1:0]        sym_bits;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] model_lfsr = SEED;
  logic [12:0] exp_q[$];
  logic [12:0] obs;

  // Observed bundle: {valid, busy, frame_done, sym_bits, x_i, x_q}
  assign obs = {valid, busy, frame_done, sym_bits, x_i_out, x_q_out};

  always #5 clk = ~clk;

  iq_burst_source #(
    .PREAMBLE_LEN(PRE_LEN),
    .PAYLOAD_LEN (PAY_LEN),
    .GAP_LEN     (GAP_LEN),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .amp       (amp),
    .ready     (ready),
    .x_i_out   (x_i_out),
    .x_q_out   (x_q_out),
    .valid     (valid),
    .sym_bits  (sym_bits),
    .busy      (busy),
    .frame_done(frame_done)
  );

  function automatic logic [3:0] lvl(input logic [1:0] a, input logic b);
    int mag;
    mag = (a == 2'd0) ? 1 : (a == 2'd1) ? 2 : (a == 2'd2) ? 4 : 7;
    return 4'(b ? -mag : mag);
  endfunction

  // Whole burst as the sequence of accepted samples; advances the model LFSR by one payload.
  task automatic build_expected(input logic [1:0] a);
    logic [1:0] s;
    int         fb;
    exp_q.delete();
    for (int p = 0; p < PRE_LEN; p++) begin
      s = (p % 2 == 1) ? 2'b11 : 2'b00;
      exp_q.push_back({3'b110, s, lvl(a, s[1]), lvl(a, s[0])});
    end
    for (int p = 0; p < PAY_LEN; p++) begin
      s = model_lfsr[1:0];
      exp_q.push_back({3'b110, s, lvl(a, s[1]), lvl(a, s[0])});
      fb = ((model_lfsr >> 15) ^ (model_lfsr >> 13) ^ (model_lfsr >> 12) ^ (model_lfsr >> 10)) & 1;
      model_lfsr = 16'((int'(model_lfsr) * 2 + fb) % 65536);
    end
    for (int p = 0; p < GAP_LEN; p++)
      exp_q.push_back({3'b110, 2'b00, 4'd0, 4'd0});
  endtask

  // mode: 0 ready high, 1 ready toggling, 2 random ready.
  task automatic run_burst(input string name, input logic [1:0] a, input int mode,
                           input bit hold_start, input bit poke, input int rst_at,
                           input int exp_cycles);
    int          idx;
    int          vcyc;
    int          budget;
    logic [12:0] e;
    build_expected(a);
    idx    = 0;
    vcyc   = 0;
    budget = 0;
    amp    = a;
    start  = 1'b1;
    ready  = 1'b1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    forever begin
      budget++;
      if (budget > 4000) begin
        vectors++;
        miscompares++;
        $display("FAIL %s timeout: accepted %0d of %0d samples", name, idx, TOTAL);
        start = 1'b0;
        return;
      end
      vectors++;
      if (idx < TOTAL) begin
        e = exp_q[idx];
        if (obs !== e) begin
          miscompares++;
          $display("FAIL %s sample %0d: got %b expected %b", name, idx, obs, e);
        end
        vcyc++;
      end else begin
        e = 13'b0010000000000;
        if (obs !== e) begin
          miscompares++;
          $display("FAIL %s frame end: got %b expected %b", name, obs, e);
        end
        if (exp_cycles > 0) begin
          vectors++;
          if (vcyc !== exp_cycles) begin
            miscompares++;
            $display("FAIL %s burst length: got %0d valid cycles expected %0d", name, vcyc, exp_cycles);
          end
        end
        if (!hold_start) begin
          @(negedge clk);
          vectors++;
          if (obs !== 13'd0) begin
            miscompares++;
            $display("FAIL %s idle after frame: got %b expected 0", name, obs);
          end
        end
        return;
      end

      if (rst_at >= 0 && idx == rst_at) begin
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs !== 13'd0) begin
          miscompares++;
          $display("FAIL %s outputs after reset: got %b expected 0", name, obs);
        end
        rst        = 1'b1;
        start      = 1'b0;
        model_lfsr = SEED;
        return;
      end

      if (poke) begin
        if (idx >= PRE_LEN + 10 && idx < PRE_LEN + 15) begin
          start = 1'b1;
          amp   = 2'd3;
        end else begin
          start = 1'b0;
        end
      end

      case (mode)
        0:       ready = 1'b1;
        1:       ready = ~ready;
        default: ready = ($urandom_range(0, 3) != 0);
      endcase
      if (ready) idx++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b1;
    ready = 1'b1;
    amp   = 2'd3;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (obs !== 13'd0) begin
        miscompares++;
        $display("FAIL reset hold: got %b expected 0", obs);
      end
    end
    start = 1'b0;
    rst   = 1'b1;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (obs !== 13'd0) begin
        miscompares++;
        $display("FAIL reset release: got %b expected 0", obs);
      end
    end
    model_lfsr = SEED;
  endtask

  task automatic test_nominal();
    run_burst("nominal", 2'd3, 0, 1'b0, 1'b0, -1, TOTAL);
  endtask

  task automatic test_backpressure();
    run_burst("backpressure", 2'd3, 1, 1'b0, 1'b0, -1, 2 * TOTAL);
  endtask

  task automatic test_ignored_controls();
    run_burst("ignored_ctrl", 2'd1, 0, 1'b0, 1'b1, -1, TOTAL);
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if (obs !== 13'd0) begin
        miscompares++;
        $display("FAIL ignored_ctrl no second burst: got %b expected 0", obs);
      end
    end
  endtask

  task automatic test_lfsr_continuity();
    logic [1:0] a;
    a = 2'($urandom_range(0, 3));
    run_burst("b2b_first", a, 0, 1'b1, 1'b0, -1, TOTAL);
    run_burst("b2b_second", a, 0, 1'b0, 1'b0, -1, TOTAL);
  endtask

  task automatic test_midburst_reset();
    run_burst("mid_reset", 2'd3, 0, 1'b0, 1'b0, PRE_LEN + 30, 0);
    @(negedge clk);
    vectors++;
    if (obs !== 13'd0) begin
      miscompares++;
      $display("FAIL mid_reset stays idle: got %b expected 0", obs);
    end
    run_burst("replay", 2'd3, 0, 1'b0, 1'b0, -1, TOTAL);
  endtask

  task automatic test_random_traffic();
    for (int n = 0; n < 4; n++)
      run_burst("random", 2'($urandom_range(0, 3)), 2, 1'b0, 1'b0, -1, 0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_ignored_controls();
    test_lfsr_continuity();
    test_midburst_reset();
    test_random_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
